// File: rtl/taillight_pkg.sv
// taillight_pkg: shared light-mode encodings, switch sample layout and limits
// for the tail-light sequencer and its output decoder.
package taillight_pkg;

  localparam int unsigned ST_W  = 4;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned HAZ_W = 3;

  localparam logic [ST_W-1:0] S_IDLE    = 4'b0000;
  localparam logic [ST_W-1:0] S_HAZARD  = 4'b0001;
  localparam logic [ST_W-1:0] S_TURN    = 4'b0010;
  localparam logic [ST_W-1:0] S_BRAKE   = 4'b0011;
  localparam logic [ST_W-1:0] S_RIGHT   = 4'b0100;
  localparam logic [ST_W-1:0] S_LEFT    = 4'b0101;
  localparam logic [ST_W-1:0] S_B_RIGHT = 4'b0110;
  localparam logic [ST_W-1:0] S_B_LEFT  = 4'b0111;

  localparam logic [CNT_W-1:0] COUNT_MAX = 3'd5;
  localparam logic [HAZ_W-1:0] HAZ_ON    = 3'b111;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE    = S_IDLE,
    ST_HAZARD  = S_HAZARD,
    ST_TURN    = S_TURN,
    ST_BRAKE   = S_BRAKE,
    ST_RIGHT   = S_RIGHT,
    ST_LEFT    = S_LEFT,
    ST_B_RIGHT = S_B_RIGHT,
    ST_B_LEFT  = S_B_LEFT
  } light_state_e;

  // One sample of the four driver switches.
  typedef struct packed {
    logic hazard_sw;
    logic brake;
    logic left;
    logic right;
  } sw_sample_t;

  // True for the four sweep states (with or without brake).
  function automatic logic is_turn(input logic [ST_W-1:0] s);
    return (s == S_LEFT) || (s == S_B_LEFT) || (s == S_RIGHT) || (s == S_B_RIGHT);
  endfunction

  // True when a sweep state points left; only meaningful when is_turn(s).
  function automatic logic is_left_dir(input logic [ST_W-1:0] s);
    return (s == S_LEFT) || (s == S_B_LEFT);
  endfunction

endpackage

// File: rtl/taillight_fsm_tick_gen.sv
// tick_gen: free-running divider producing a one-clk animation tick every
// TICK_DIV clocks. The tick is registered and lines up with the divider's
// terminal count, so the first tick takes effect TICK_DIV edges after reset.
module tick_gen #(
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'(TICK_DIV - 2);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Divider count 0..TICK_DIV-1 with the tick raised one clk ahead so it is high at LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
      r_tick <= (r_cnt == PRE);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/taillight_fsm.sv
// taillight_fsm: light-mode sequencer feeding the tail-light decoder.
// Optional macro TAILLIGHT_INSYNC_EN inserts a two-flop synchronizer on each
// switch; without it the switches drive the next-state logic directly.
module taillight_fsm
  import taillight_pkg::*;
#(
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             left,
  input  logic             right,
  input  logic             hazard_sw,
  input  logic             brake,
  output logic [ST_W-1:0]  CurrentState,
  output logic [CNT_W-1:0] counter,
  output logic [HAZ_W-1:0] hazard
);

  sw_sample_t       w_sw_raw;
  sw_sample_t       w_sw;
  logic             w_tick;
  light_state_e     r_state;
  light_state_e     w_next;
  logic [CNT_W-1:0] r_counter;
  logic [CNT_W-1:0] w_counter_next;
  logic [HAZ_W-1:0] r_hazard;
  logic [HAZ_W-1:0] w_hazard_next;

  assign w_sw_raw.hazard_sw = hazard_sw;
  assign w_sw_raw.brake     = brake;
  assign w_sw_raw.left      = left;
  assign w_sw_raw.right     = right;

`ifdef TAILLIGHT_INSYNC_EN
  sw_sample_t r_sync1;
  sw_sample_t r_sync2;

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_sw_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sw = r_sync2;
`else
  assign w_sw = w_sw_raw;
`endif

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  // State, sweep counter and blink pattern registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_counter <= '0;
      r_hazard  <= '0;
    end else begin
      r_state   <= w_next;
      r_counter <= w_counter_next;
      r_hazard  <= w_hazard_next;
    end
  end

  // Next state from switches (first match wins), then counter/blink next values.
  always_comb begin
    w_next         = ST_IDLE;
    w_counter_next = '0;
    w_hazard_next  = '0;

    case (r_state)
      ST_IDLE, ST_HAZARD, ST_BRAKE, ST_RIGHT, ST_LEFT, ST_B_RIGHT, ST_B_LEFT: begin
        if (w_sw.hazard_sw || (w_sw.left && w_sw.right)) begin
          w_next = ST_HAZARD;
        end else if (w_sw.brake && w_sw.left) begin
          w_next = ST_B_LEFT;
        end else if (w_sw.brake && w_sw.right) begin
          w_next = ST_B_RIGHT;
        end else if (w_sw.left) begin
          w_next = ST_LEFT;
        end else if (w_sw.right) begin
          w_next = ST_RIGHT;
        end else if (w_sw.brake) begin
          w_next = ST_BRAKE;
        end else begin
          w_next = ST_IDLE;
        end
      end
      // Reserved Turn and any corrupted encoding recover to Idle.
      default: w_next = ST_IDLE;
    endcase

    // Sweep restarts on entry or direction change; brake toggling keeps its phase.
    if (is_turn(w_next)) begin
      if (!is_turn(r_state) || (is_left_dir(w_next) != is_left_dir(r_state))) begin
        w_counter_next = '0;
      end else if (w_tick) begin
        w_counter_next = (r_counter >= COUNT_MAX) ? '0 : r_counter + CNT_W'(1);
      end else begin
        w_counter_next = r_counter;
      end
    end

    // Blink starts lit on entry, then inverts every tick while hazard holds.
    if (w_next == ST_HAZARD) begin
      if (r_state != ST_HAZARD) begin
        w_hazard_next = HAZ_ON;
      end else if (w_tick) begin
        w_hazard_next = ~r_hazard;
      end else begin
        w_hazard_next = r_hazard;
      end
    end
  end

  assign CurrentState = r_state;
  assign counter      = r_counter;
  assign hazard       = r_hazard;

endmodule

// File: tb/tb_taillight_fsm.sv
// tb_taillight_fsm: directed scenarios with a queue-based scoreboard.
// Stimulus pushes expected outputs tagged with the absolute clk edge after
// which they must hold; a monitor samples on each falling edge (and right
// after an asynchronous reset assertion) and compares.
module tb_taillight_fsm;

`ifdef TAILLIGHT_INSYNC_EN
  localparam int L = 3;
`else
  localparam int L = 1;
`endif

  localparam logic [3:0] E_IDLE    = 4'b0000;
  localparam logic [3:0] E_HAZARD  = 4'b0001;
  localparam logic [3:0] E_BRAKE   = 4'b0011;
  localparam logic [3:0] E_RIGHT   = 4'b0100;
  localparam logic [3:0] E_LEFT    = 4'b0101;
  localparam logic [3:0] E_B_RIGHT = 4'b0110;
  localparam logic [3:0] E_B_LEFT  = 4'b0111;

  logic       clk;
  logic       rst;
  logic       left;
  logic       right;
  logic       hazard_sw;
  logic       brake;
  logic [3:0] cur_state;
  logic [2:0] counter;
  logic [2:0] hazard;

  int gcyc   = 0;
  int ecnt   = 0;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         at;
    bit         on_rst;
    logic [3:0] st;
    logic [2:0] cnt;
    logic [2:0] hz;
    string      name;
  } exp_t;

  exp_t sb[$];

  taillight_fsm #(
    .TICK_DIV (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .left         (left),
    .right        (right),
    .hazard_sw    (hazard_sw),
    .brake        (brake),
    .CurrentState (cur_state),
    .counter      (counter),
    .hazard       (hazard)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) gcyc <= gcyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  task automatic push_exp(input int n, input logic [3:0] st, input logic [2:0] cnt,
                          input logic [2:0] hz, input string nm);
    exp_t e;
    e.at = gcyc + n; e.on_rst = 1'b0; e.st = st; e.cnt = cnt; e.hz = hz; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_entry(input exp_t e);
    n_tests++;
    if (cur_state !== e.st || counter !== e.cnt || hazard !== e.hz) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got state=%b counter=%0d hazard=%b, want state=%b counter=%0d hazard=%b",
               e.name, gcyc, cur_state, counter, hazard, e.st, e.cnt, e.hz);
    end
  endtask

  // Monitor: pops and compares entries that are due.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or posedge rst);
      #1;
      while (sb.size() > 0) begin
        e = sb[0];
        if (e.on_rst) begin
          if (rst) begin
            void'(sb.pop_front());
            check_entry(e);
          end else break;
        end else if (e.at == gcyc) begin
          void'(sb.pop_front());
          check_entry(e);
        end else if (e.at < gcyc) begin
          void'(sb.pop_front());
          n_tests++;
          n_fail++;
          $display("FAIL %s: check for edge %0d missed, now at edge %0d", e.name, e.at, gcyc);
        end else break;
      end
    end
  end

  initial begin
    exp_t er;
    rst = 1'b1; left = 1'b0; right = 1'b0; hazard_sw = 1'b0; brake = 1'b0;
    push_exp(1, E_IDLE, 3'd0, 3'b000, "reset_state");
    #12;
    rst = 1'b0;
    adv(1);

    // Idle with all switches low
    for (int n = 0; n < 20; n++) push_exp(n, E_IDLE, 3'd0, 3'b000, "idle");
    adv(19);

    // Left sweep, ticks every 4 clks
    while (ecnt % 4 != 0) adv(1);
    left = 1'b1;
    push_exp(L, E_LEFT, 3'd0, 3'b000, "left_entry");
    for (int k = 1; k <= 6; k++) begin
      push_exp(4 * k,     E_LEFT, 3'(k % 6), 3'b000, "left_sweep");
      push_exp(4 * k + 3, E_LEFT, 3'(k % 6), 3'b000, "left_hold");
    end
    adv(36);

    // Brake mid-sweep keeps the phase; direction change clears it
    brake = 1'b1;
    push_exp(L, E_B_LEFT, 3'd3, 3'b000, "brake_keep");
    push_exp(4, E_B_LEFT, 3'd4, 3'b000, "brake_tick");
    adv(4);
    left = 1'b0; right = 1'b1;
    push_exp(L, E_B_RIGHT, 3'd0, 3'b000, "dir_clear");
    push_exp(4, E_B_RIGHT, 3'd1, 3'b000, "b_right_tick");
    adv(4);

    // Left+right together gives hazard blinking
    left = 1'b1; right = 1'b1; brake = 1'b0;
    push_exp(L,  E_HAZARD, 3'd0, 3'b111, "haz_entry");
    push_exp(4,  E_HAZARD, 3'd0, 3'b000, "haz_blink0");
    push_exp(8,  E_HAZARD, 3'd0, 3'b111, "haz_blink1");
    push_exp(12, E_HAZARD, 3'd0, 3'b000, "haz_blink2");
    adv(12);

    // Hazard switch outranks brake; release falls back to brake
    hazard_sw = 1'b1; brake = 1'b1; left = 1'b0; right = 1'b0;
    push_exp(L, E_HAZARD, 3'd0, 3'b000, "haz_prio");
    push_exp(4, E_HAZARD, 3'd0, 3'b111, "haz_prio_tick");
    adv(4);
    hazard_sw = 1'b0;
    push_exp(L, E_BRAKE, 3'd0, 3'b000, "brake_only");
    adv(4);

    // Right sweep to counter 4, then asynchronous reset between edges
    brake = 1'b0; right = 1'b1;
    push_exp(L, E_RIGHT, 3'd0, 3'b000, "right_entry");
    for (int k = 1; k <= 4; k++) push_exp(4 * k, E_RIGHT, 3'(k), 3'b000, "right_sweep");
    adv(16);
    #6;
    er.at = gcyc; er.on_rst = 1'b1; er.st = E_IDLE; er.cnt = 3'd0; er.hz = 3'b000;
    er.name = "async_reset";
    sb.push_back(er);
    rst = 1'b1;
    push_exp(1, E_IDLE, 3'd0, 3'b000, "in_reset");
    @(posedge clk);
    #7;
    rst = 1'b0;
    for (int n = 1; n <= 4; n++)
      push_exp(n, (n >= L) ? E_RIGHT : E_IDLE, (n >= 4) ? 3'd1 : 3'd0, 3'b000, "post_reset");
    adv(6);

    // Drain with a bounded wait
    for (int i = 0; i < 50 && sb.size() > 0; i++) adv(1);
    while (sb.size() > 0) begin
      er = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: never checked (due edge %0d, now %0d)", er.name, er.at, gcyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
